div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 12 +
 rtl/div_counter.sv | 40 ++++
 rtl/div_ctrl.sv | 82 ++++++++
 tb/tb_div_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared defaults and state encoding for the programmable clock divider.
package div_ctrl_pkg;

  localparam int unsigned CNT_W_DEF       = 26;
  localparam int unsigned DEFAULT_DIV_DEF = 25_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/div_counter.sv
// Half-period counter with terminal-count detect and registered q/tick outputs.
module div_counter
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             tc,
  output logic             q,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign tc = run && (count == (div - CNT_W'(1)));

  // Dropping run clears everything, so entering RUN always starts from zero with q low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      q     <= 1'b0;
      tick  <= 1'b0;
    end else if (!run) begin
      count <= '0;
      q     <= 1'b0;
      tick  <= 1'b0;
    end else if (tc) begin
      count <= '0;
      q     <= ~q;
      tick  <= 1'b1;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divider controller: IDLE/RUN FSM, config handshake, divide register and pending update.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             q,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  state_t           state;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend_div;
  logic             pend_valid;
  logic             run;
  logic             tc;
  logic             cfg_fire;

  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE) || !pend_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign run       = (state == RUN) && !stop;

  div_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .div  (div_reg),
    .tc   (tc),
    .q    (q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_reg    <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !stop) state <= RUN;
        RUN:  if (stop) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A pending value exists only in RUN and blocks the handshake, so these never collide.
      if ((state == RUN) && (tc || stop) && pend_valid) begin
        div_reg    <= pend_div;
        pend_valid <= 1'b0;
      end

      if (cfg_fire) begin
        if (cfg_div == '0) begin
          cfg_err <= 1'b1;
        end else begin
          cfg_err <= 1'b0;
          if ((state == IDLE) || tc || stop) begin
            div_reg <= cfg_div;
          end else begin
            pend_div   <= cfg_div;
            pend_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: a countdown reference model predicts every cycle's outputs.
module tb_div_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic q;
    logic tick;
    logic busy;
    logic ready;
    logic err;
  } obs_t;

  logic         clk;
  logic         reset;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         start;
  logic         stop;
  logic         q;
  logic         tick;
  logic         busy;
  logic         cfg_err;

  int vectors;
  int miscompares;

  obs_t exp_q[$];

  // Reference model state: time left to the next toggle instead of an up-counter.
  logic         m_run;
  logic         m_q;
  logic         m_tick;
  logic [W-1:0] m_div;
  logic         m_pend;
  logic [W-1:0] m_pend_div;
  logic         m_err;
  int           m_left;

  div_ctrl #(
    .CNT_W      (W),
    .DEFAULT_DIV(5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .start    (start),
    .stop     (stop),
    .q        (q),
    .tick     (tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run      = 1'b0;
    m_q        = 1'b0;
    m_tick     = 1'b0;
    m_div      = W'(5);
    m_pend     = 1'b0;
    m_pend_div = '0;
    m_err      = 1'b0;
    m_left     = 0;
  endtask

  // Called at a falling edge: drive inputs, predict the state after the next rising edge.
  task automatic step(input logic s, input logic p, input logic cv, input logic [W-1:0] cd);
    logic rdy;
    logic fire;
    logic good;
    obs_t e;
    start     = s;
    stop      = p;
    cfg_valid = cv;
    cfg_div   = cd;
    rdy  = !m_run || !m_pend;
    fire = cv && rdy;
    good = fire && (cd != 0);
    if (fire) m_err = (cd == 0);
    if (!m_run) begin
      m_q    = 1'b0;
      m_tick = 1'b0;
      if (good) m_div = cd;
      if (s && !p) begin
        m_run  = 1'b1;
        m_left = int'(m_div);
      end
    end else if (p) begin
      m_run  = 1'b0;
      m_q    = 1'b0;
      m_tick = 1'b0;
      if (m_pend) begin
        m_div  = m_pend_div;
        m_pend = 1'b0;
      end
      if (good) m_div = cd;
    end else if (m_left == 1) begin
      m_q    = !m_q;
      m_tick = 1'b1;
      if (m_pend) begin
        m_div  = m_pend_div;
        m_pend = 1'b0;
      end
      if (good) m_div = cd;
      m_left = int'(m_div);
    end else begin
      m_left = m_left - 1;
      m_tick = 1'b0;
      if (good) begin
        m_pend     = 1'b1;
        m_pend_div = cd;
      end
    end
    e.q     = m_q;
    e.tick  = m_tick;
    e.busy  = m_run;
    e.ready = !m_run || !m_pend;
    e.err   = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: every rising edge that has a prediction queued is checked just after the edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{q: q, tick: tick, busy: busy, ready: cfg_ready, err: cfg_err};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got q=%b tick=%b busy=%b ready=%b err=%b, expected q=%b tick=%b busy=%b ready=%b err=%b",
                   $time, a.q, a.tick, a.busy, a.ready, a.err, e.q, e.tick, e.busy, e.ready, e.err);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cfg_valid   = 1'b0;
    cfg_div     = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check1("reset_q", q, 1'b0);
    check1("reset_tick", tick, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_ready", cfg_ready, 1'b1);
    check1("reset_err", cfg_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Stays idle until start, then default divide of 5.
    idle_steps(3);
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(17);
    step(1'b0, 1'b1, 1'b0, '0);
    idle_steps(2);

    // Divide by 3 loaded while idle.
    step(1'b0, 1'b0, 1'b1, W'(3));
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(14);
    step(1'b0, 1'b1, 1'b0, '0);

    // Divide by 4, then 2 offered mid-period; 6 held while not ready.
    step(1'b0, 1'b0, 1'b1, W'(4));
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(2);
    step(1'b0, 1'b0, 1'b1, W'(2));
    step(1'b0, 1'b0, 1'b1, W'(6));
    idle_steps(12);
    step(1'b0, 1'b1, 1'b0, '0);

    // Zero divide is rejected, then a good value clears the flag.
    step(1'b0, 1'b0, 1'b1, W'(0));
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(8);
    step(1'b0, 1'b1, 1'b1, W'(7));
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    idle_steps(2);

    // Divide by 1: toggle and tick every cycle.
    step(1'b0, 1'b0, 1'b1, W'(1));
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(6);
    step(1'b1, 1'b1, 1'b0, '0);

    // Reset mid-period with q high.
    step(1'b0, 1'b0, 1'b1, W'(4));
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(6);
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check1("midreset_q", q, 1'b0);
    check1("midreset_tick", tick, 1'b0);
    check1("midreset_ready", cfg_ready, 1'b1);
    check1("midreset_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle_steps(7);
    step(1'b1, 1'b0, 1'b0, '0);
    idle_steps(12);

    for (int i = 0; i < 500; i++) begin
      step(($urandom % 8) == 0, ($urandom % 20) == 0, ($urandom % 4) == 0,
           W'($urandom_range(0, 6)));
    end

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
